// File: rtl/hss_pkg.sv
// Shared types and helpers for the HSS receive word aligner.
package hss_pkg;

  localparam int unsigned SyncW = 8;
  // The sync lane transmits a single set bit in the LSB position every word.
  localparam logic [SyncW-1:0] SyncPattern = 8'h01;

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLocked
  } align_state_t;

  // Returns {valid, idx}: valid only when exactly one bit of word is set,
  // idx is the position of that bit.
  function automatic logic [3:0] onehot_idx(input logic [SyncW-1:0] word);
    logic [3:0] ones;
    logic [2:0] idx;
    ones = '0;
    idx  = '0;
    for (int i = 0; i < SyncW; i++) begin
      if (word[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end
    end
    return {(ones == 4'd1), idx};
  endfunction

endpackage

// File: rtl/hss_lane_gearbox.sv
// Per-lane realignment: keeps the last two deserialised words and extracts the
// byte that starts at the selected slip with a registered barrel shift.
module hss_lane_gearbox
  import hss_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] din_i,
  input  logic [2:0] shift_i,
  output logic [7:0] dout_o
);

  logic [15:0] hist_q, hist_d;
  logic [15:0] shifted;
  logic [7:0]  dout_q, dout_d;

  // Newest word enters at the top; extraction works on the pre-update history.
  always_comb begin
    hist_d  = {din_i, hist_q[15:8]};
    shifted = hist_q >> shift_i;
    dout_d  = shifted[7:0];
  end

  // History and output byte registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      dout_q <= '0;
    end else begin
      hist_q <= hist_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/hss_rx_aligner.sv
// Receive word aligner: qualifies the bit slip from the one-hot sync lane with a
// lock FSM (hysteresis in both directions), realigns the data lanes and keeps
// saturating link-health counters.
module hss_rx_aligner
  import hss_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned LockCnt   = 4,
  parameter int unsigned UnlockCnt = 3,
  parameter int unsigned CntW      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SyncW-1:0] rx_sync_i,
  input  logic [N*8-1:0]   rx_data_i,
  input  logic             cnt_clr_i,
  output logic [N*8-1:0]   rx_dout_o,
  output logic             rx_valid_o,
  output logic             locked_o,
  output logic [2:0]       shift_o,
  output logic [CntW-1:0]  sync_err_cnt_o,
  output logic [7:0]       lock_loss_cnt_o
);

  localparam int unsigned LockW   = $clog2(LockCnt + 1);
  localparam int unsigned UnlockW = $clog2(UnlockCnt + 1);
  localparam logic [LockW-1:0]   LockLast   = LockW'(LockCnt - 1);
  localparam logic [UnlockW-1:0] UnlockLast = UnlockW'(UnlockCnt - 1);

  align_state_t        state_q, state_d;
  logic [2:0]          cand_q, cand_d;
  logic [2:0]          shift_q, shift_d;
  logic [LockW-1:0]    cnt_q, cnt_d;
  logic [UnlockW-1:0]  bad_q, bad_d;
  logic                locked_q, locked_d;
  logic                valid_q, valid_d;
  logic [CntW-1:0]     err_q, err_d;
  logic [7:0]          loss_q, loss_d;
  logic                err_inc, loss_inc;

  logic       sync_valid;
  logic [2:0] sync_idx;

  assign {sync_valid, sync_idx} = onehot_idx(rx_sync_i);

  // State register: FSM, slip bookkeeping, status flags and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StHunt;
      cand_q   <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      loss_q   <= loss_d;
    end
  end

  // Next-state logic for the lock FSM and its match/bad run counters.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    err_inc  = 1'b0;
    loss_inc = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (sync_valid) begin
          cand_d = sync_idx;
          cnt_d  = LockW'(1);
          if (LockCnt == 1) begin
            state_d = StLocked;
            shift_d = sync_idx;
            bad_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (rx_sync_i == (SyncPattern << cand_q)) begin
          if (cnt_q == LockLast) begin
            state_d = StLocked;
            shift_d = cand_q;
            bad_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LockW'(1);
          end
        end else begin
          // A breaking word is discarded, not promoted to a new candidate.
          state_d = StHunt;
          cnt_d   = '0;
        end
      end
      StLocked: begin
        if (rx_sync_i == (SyncPattern << shift_q)) begin
          bad_d = '0;
        end else begin
          err_inc = 1'b1;
          if (bad_q == UnlockLast) begin
            state_d  = StHunt;
            bad_d    = '0;
            loss_inc = 1'b1;
          end else begin
            bad_d = bad_q + UnlockW'(1);
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // Registered status outputs and saturating counters; clear beats increment.
  always_comb begin
    locked_d = (state_d == StLocked);
    valid_d  = locked_q;
    err_d    = err_q;
    loss_d   = loss_q;
    if (cnt_clr_i) begin
      err_d  = '0;
      loss_d = '0;
    end else begin
      if (err_inc && (err_q != '1)) begin
        err_d = err_q + CntW'(1);
      end
      if (loss_inc && (loss_q != '1)) begin
        loss_d = loss_q + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    hss_lane_gearbox u_gearbox (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .din_i   (rx_data_i[g*8 +: 8]),
      .shift_i (shift_q),
      .dout_o  (rx_dout_o[g*8 +: 8])
    );
  end

  assign rx_valid_o      = valid_q;
  assign locked_o        = locked_q;
  assign shift_o         = shift_q;
  assign sync_err_cnt_o  = err_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_hss_rx_aligner.sv
// Bench for hss_rx_aligner: a bit-level slipped tx stream feeds the lanes, the
// driver pushes the expected aligned word for every cycle it expects to be
// locked, and a negedge monitor pops and compares whenever rx_valid is high.
`timescale 1ns/1ps
module tb_hss_rx_aligner;

  localparam int unsigned N    = 3;
  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic [7:0]      rx_sync;
  logic [N*8-1:0]  rx_data;
  logic            cnt_clr;
  logic [N*8-1:0]  rx_dout;
  logic            rx_valid;
  logic            locked;
  logic [2:0]      shift;
  logic [CntW-1:0] sync_err_cnt;
  logic [7:0]      lock_loss_cnt;

  hss_rx_aligner #(
    .N         (N),
    .LockCnt   (4),
    .UnlockCnt (3),
    .CntW      (CntW)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_sync_i       (rx_sync),
    .rx_data_i       (rx_data),
    .cnt_clr_i       (cnt_clr),
    .rx_dout_o       (rx_dout),
    .rx_valid_o      (rx_valid),
    .locked_o        (locked),
    .shift_o         (shift),
    .sync_err_cnt_o  (sync_err_cnt),
    .lock_loss_cnt_o (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [N*8-1:0] sb[$];
  logic [N*8-1:0] mon_exp;
  logic [7:0] tx_prev [N];
  int txcnt = 0;
  int slip  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rx_dout: rx_valid with nothing expected, got 0x%0h at %0t",
                 rx_dout, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("rx_dout", 32'(rx_dout), 32'(mon_exp));
      end
    end
  end

  // One received word per lane. The tx stream is delayed by `slip` bits, so the
  // received word is the top byte of {t_k, t_(k-1)} << slip, and once locked the
  // aligner should return t_(k-1) one edge later.
  task automatic step(input logic [7:0] sync, input bit exp_lock, input bit clr = 1'b0);
    logic [N*8-1:0] d, e;
    logic [7:0]     tk;
    logic [15:0]    w;
    for (int i = 0; i < N; i++) begin
      tk = 8'(txcnt + i * 85);
      w  = {tk, tx_prev[i]} << slip;
      d[i*8 +: 8] = w[15:8];
      e[i*8 +: 8] = tx_prev[i];
      tx_prev[i]  = tk;
    end
    rx_sync = sync;
    rx_data = d;
    cnt_clr = clr;
    if (exp_lock) sb.push_back(e);
    @(posedge clk);
    #1;
    chk("locked", 32'(locked), 32'(exp_lock));
    txcnt++;
  endtask

  task automatic repeat_step(input int n, input logic [7:0] sync, input bit exp_lock);
    for (int i = 0; i < n; i++) step(sync, exp_lock);
  endtask

  task automatic lock_up(input logic [7:0] sync);
    repeat_step(3, sync, 1'b0);
    step(sync, 1'b1);
  endtask

  task automatic unlock_and_drain();
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("rx_valid_idle", 32'(rx_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_shift"}, 32'(shift), 32'd0);
    chk({tag, "_dout"}, 32'(rx_dout), 32'd0);
    chk({tag, "_errcnt"}, 32'(sync_err_cnt), 32'd0);
    chk({tag, "_losscnt"}, 32'(lock_loss_cnt), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    rx_sync = '0;
    rx_data = '0;
    cnt_clr = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rx_sync = '0;
    rx_data = '0;
    cnt_clr = 1'b0;
    for (int i = 0; i < N; i++) tx_prev[i] = '0;
    #12;
    check_all_zero("reset");
    apply_reset();

    // Aligned stream, lock on the 4th match, then bad-word hysteresis.
    slip = 0;
    lock_up(8'h01);
    repeat_step(6, 8'h01, 1'b1);
    chk("t1_errcnt", 32'(sync_err_cnt), 32'd0);
    chk("t1_shift", 32'(shift), 32'd0);
    step(8'h00, 1'b1);
    step(8'h02, 1'b1);
    step(8'h01, 1'b1);
    chk("t4_errcnt_2", 32'(sync_err_cnt), 32'd2);
    chk("t4_losscnt_0", 32'(lock_loss_cnt), 32'd0);
    step(8'h00, 1'b1);
    step(8'h80, 1'b1);
    step(8'h03, 1'b0);
    chk("t4_errcnt_5", 32'(sync_err_cnt), 32'd5);
    chk("t4_losscnt_1", 32'(lock_loss_cnt), 32'd1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);
    chk("t4_valid_low", 32'(rx_valid), 32'd0);

    // Stream slipped by 5 bits.
    apply_reset();
    slip = 5;
    lock_up(8'h20);
    repeat_step(8, 8'h20, 1'b1);
    chk("t2_shift", 32'(shift), 32'd5);
    step(8'h01, 1'b1);
    step(8'h00, 1'b1);
    step(8'h20, 1'b1);
    unlock_and_drain();
    chk("t2_shift_held", 32'(shift), 32'd5);
    chk("t2_errcnt", 32'(sync_err_cnt), 32'd5);

    // Broken candidate run in CHECK restarts the hunt without reuse.
    apply_reset();
    slip = 0;
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    step(8'h40, 1'b0);
    lock_up(8'h01);
    repeat_step(3, 8'h01, 1'b1);
    chk("t3_shift", 32'(shift), 32'd0);
    unlock_and_drain();

    // Invalid sync words never lock and never count.
    apply_reset();
    repeat_step(50, 8'h03, 1'b0);
    repeat_step(50, 8'h00, 1'b0);
    step(8'hFF, 1'b0);
    chk("t5_errcnt", 32'(sync_err_cnt), 32'd0);
    chk("t5_losscnt", 32'(lock_loss_cnt), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset while locked, then relock from HUNT.
    apply_reset();
    slip = 3;
    lock_up(8'h08);
    repeat_step(3, 8'h08, 1'b1);
    step(8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    apply_reset();
    lock_up(8'h08);
    chk("t6_relock_shift", 32'(shift), 32'd3);
    unlock_and_drain();

    // Counter saturation and clear priority.
    apply_reset();
    slip = 0;
    lock_up(8'h01);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      step(8'h01, 1'b1);
    end
    chk("t6_err_sat", 32'(sync_err_cnt), 32'hF);
    step(8'h00, 1'b1, 1'b1);
    chk("t6_clr_vs_inc", 32'(sync_err_cnt), 32'd0);
    step(8'h01, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);
      lock_up(8'h01);
    end
    chk("t6_loss_sat", 32'(lock_loss_cnt), 32'hFF);
    chk("t6_err_sat2", 32'(sync_err_cnt), 32'hF);
    step(8'h01, 1'b1, 1'b1);
    chk("t6_clr_err", 32'(sync_err_cnt), 32'd0);
    chk("t6_clr_loss", 32'(lock_loss_cnt), 32'd0);
    unlock_and_drain();
    chk("t6_err_after", 32'(sync_err_cnt), 32'd3);
    chk("t6_loss_after", 32'(lock_loss_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
